hamming_secded_decoder: RTL

//  Parametrised extended-Hamming (SEC-DED) decoder for the Li-Fi receive path.

---
 rtl/hamming_secded_decoder.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/hamming_secded_decoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hamming_secded_decoder : extended-Hamming SEC-DED decoder with valid/ready
//                          flow control and saturating error counters
// Revision 1.0
// ----------------------------------------------------------------------------
module hamming_secded_decoder #(
   parameter  int DATA_W = 4,
   parameter  int PIPE   = 0,
   parameter  int CNT_W  = 16,
   localparam int R      = (DATA_W <= 4)   ? 3 :
                           (DATA_W <= 11)  ? 4 :
                           (DATA_W <= 26)  ? 5 :
                           (DATA_W <= 57)  ? 6 :
                           (DATA_W <= 120) ? 7 :
                           (DATA_W <= 247) ? 8 : 9,
   localparam int CW_W   = DATA_W + R + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CW_W-1:0]   codeword,
   input  logic              correct_en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] message,
   output logic              err_corr,
   output logic              err_uncorr,
   output logic [R-1:0]      syndrome,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  corr_cnt,
   output logic [CNT_W-1:0]  uncorr_cnt
);

   function automatic logic [R-1:0] calc_syndrome(input logic [CW_W-1:0] cw);
      logic [R-1:0] s;
      s = '0;
      for (int i = 1; i < CW_W; i++) begin
         if (cw[i]) s = s ^ R'(i);
      end
      return s;
   endfunction

   // Returns {message, err_corr, err_uncorr}; data is gathered from the
   // non-power-of-two positions in ascending order.
   function automatic logic [DATA_W+1:0] decode(input logic [CW_W-1:0] cw,
                                                input logic [R-1:0]    s,
                                                input logic            p,
                                                input logic            en);
      logic [CW_W-1:0]   fixed;
      logic [DATA_W-1:0] msg;
      logic              ec;
      logic              eu;
      fixed = cw;
      msg   = '0;
      ec    = 1'b0;
      eu    = 1'b0;
      if (s == '0) begin
         ec = p;
      end else if (!p || (int'(s) >= CW_W)) begin
         eu = 1'b1;
      end else begin
         ec = 1'b1;
         if (en) fixed = cw ^ (CW_W'(1) << s);
      end
      for (int i = 1; i < CW_W; i++) begin
         if ((i & (i - 1)) != 0) msg = {fixed[i], msg[DATA_W-1:1]};
      end
      return {msg, ec, eu};
   endfunction

   logic              out_valid_q,  out_valid_d;
   logic [DATA_W-1:0] message_q,    message_d;
   logic              err_corr_q,   err_corr_d;
   logic              err_uncorr_q, err_uncorr_d;
   logic [R-1:0]      syndrome_q,   syndrome_d;
   logic [CNT_W-1:0]  corr_cnt_q,   corr_cnt_d;
   logic [CNT_W-1:0]  uncorr_cnt_q, uncorr_cnt_d;

   logic              w_out_free;
   logic              w_src_valid;
   logic [CW_W-1:0]   w_src_cw;
   logic [R-1:0]      w_src_syn;
   logic              w_src_par;
   logic              w_src_en;
   logic [DATA_W-1:0] w_msg;
   logic              w_ec;
   logic              w_eu;
   logic              w_fire;

   assign w_out_free = !out_valid_q || out_ready;

   generate
      if (PIPE != 0) begin : g_pipe
         logic            s1_valid_q, s1_valid_d;
         logic [CW_W-1:0] s1_cw_q,    s1_cw_d;
         logic [R-1:0]    s1_syn_q,   s1_syn_d;
         logic            s1_par_q,   s1_par_d;
         logic            s1_en_q,    s1_en_d;

         assign in_ready = !reset && (!s1_valid_q || w_out_free);

         always_comb begin
            s1_valid_d = s1_valid_q;
            s1_cw_d    = s1_cw_q;
            s1_syn_d   = s1_syn_q;
            s1_par_d   = s1_par_q;
            s1_en_d    = s1_en_q;
            if (!s1_valid_q || w_out_free) s1_valid_d = in_valid;
            if (in_valid && in_ready) begin
               s1_cw_d  = codeword;
               s1_syn_d = calc_syndrome(codeword);
               s1_par_d = ^codeword;
               s1_en_d  = correct_en;
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               s1_valid_q <= 1'b0;
               s1_cw_q    <= '0;
               s1_syn_q   <= '0;
               s1_par_q   <= 1'b0;
               s1_en_q    <= 1'b0;
            end else begin
               s1_valid_q <= s1_valid_d;
               s1_cw_q    <= s1_cw_d;
               s1_syn_q   <= s1_syn_d;
               s1_par_q   <= s1_par_d;
               s1_en_q    <= s1_en_d;
            end
         end

         assign w_src_valid = s1_valid_q;
         assign w_src_cw    = s1_cw_q;
         assign w_src_syn   = s1_syn_q;
         assign w_src_par   = s1_par_q;
         assign w_src_en    = s1_en_q;
      end else begin : g_direct
         assign in_ready    = !reset && w_out_free;
         assign w_src_valid = in_valid && in_ready;
         assign w_src_cw    = codeword;
         assign w_src_syn   = calc_syndrome(codeword);
         assign w_src_par   = ^codeword;
         assign w_src_en    = correct_en;
      end
   endgenerate

   always_comb begin
      {w_msg, w_ec, w_eu} = decode(w_src_cw, w_src_syn, w_src_par, w_src_en);
      out_valid_d  = out_valid_q;
      message_d    = message_q;
      err_corr_d   = err_corr_q;
      err_uncorr_d = err_uncorr_q;
      syndrome_d   = syndrome_q;
      if (w_out_free) begin
         out_valid_d = w_src_valid;
         if (w_src_valid) begin
            message_d    = w_msg;
            err_corr_d   = w_ec;
            err_uncorr_d = w_eu;
            syndrome_d   = w_src_syn;
         end
      end

      // Clear takes priority over a same-cycle increment.
      w_fire       = out_valid_q && out_ready;
      corr_cnt_d   = corr_cnt_q;
      uncorr_cnt_d = uncorr_cnt_q;
      if (cnt_clr) begin
         corr_cnt_d   = '0;
         uncorr_cnt_d = '0;
      end else if (w_fire) begin
         if (err_corr_q && (corr_cnt_q != '1))     corr_cnt_d   = corr_cnt_q + CNT_W'(1);
         if (err_uncorr_q && (uncorr_cnt_q != '1)) uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q  <= 1'b0;
         message_q    <= '0;
         err_corr_q   <= 1'b0;
         err_uncorr_q <= 1'b0;
         syndrome_q   <= '0;
         corr_cnt_q   <= '0;
         uncorr_cnt_q <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         message_q    <= message_d;
         err_corr_q   <= err_corr_d;
         err_uncorr_q <= err_uncorr_d;
         syndrome_q   <= syndrome_d;
         corr_cnt_q   <= corr_cnt_d;
         uncorr_cnt_q <= uncorr_cnt_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign message    = message_q;
   assign err_corr   = err_corr_q;
   assign err_uncorr = err_uncorr_q;
   assign syndrome   = syndrome_q;
   assign corr_cnt   = corr_cnt_q;
   assign uncorr_cnt = uncorr_cnt_q;

endmodule
`default_nettype wire
